// File: rtl/accumulator_pkg.sv
// Shared types and the extended saturating/wrapping add used by the
// multichannel accumulator.
package accumulator_pkg;

  localparam int SAT_W = 64;
  localparam logic [SAT_W:0] SAT_ONE = {{SAT_W{1'b0}}, 1'b1};

  typedef enum logic {
    DUMP_IDLE = 1'b0,
    DUMP_HOLD = 1'b1
  } dump_state_e;

  // Operands arrive already extended to SAT_W bits; acc_w is the real width.
  // Returns {overflow, result}, result valid in its low acc_w bits.
  function automatic logic [SAT_W:0] sat_add(
    input logic [SAT_W-1:0] acc,
    input logic [SAT_W-1:0] data,
    input int unsigned      acc_w,
    input logic             is_signed,
    input logic             saturate
  );
    logic [SAT_W:0] sum;
    logic [SAT_W:0] s_max;
    logic [SAT_W:0] s_min;
    logic [SAT_W:0] u_max;
    logic [SAT_W:0] res;
    logic           ovf;
    sum   = {is_signed & acc[SAT_W-1], acc} + {is_signed & data[SAT_W-1], data};
    s_max = (SAT_ONE << (acc_w - 32'd1)) - SAT_ONE;
    s_min = ~s_max;
    u_max = (SAT_ONE << acc_w) - SAT_ONE;
    if (is_signed) begin
      ovf = ($signed(sum) > $signed(s_max)) || ($signed(sum) < $signed(s_min));
    end else begin
      ovf = (sum > u_max);
    end
    if (ovf && saturate) begin
      res = is_signed ? (sum[SAT_W] ? s_min : s_max) : u_max;
    end else begin
      res = sum;
    end
    return {ovf, res[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/accumulator_sat_add.sv
// Combinational write-path adder: extends both operands, adds, flags
// overflow and clamps or wraps according to SATURATE.
module accumulator_sat_add
  import accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 1
) (
  input  logic [ACC_WIDTH-1:0]  acc_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [ACC_WIDTH-1:0]  sum_o,
  output logic                  ovf_o
);

  localparam logic SGN = (SIGNED != 0);
  localparam logic SAT = (SATURATE != 0);

  logic [SAT_W-1:0]         acc_x;
  logic [SAT_W-1:0]         data_x;
  logic [SAT_W:0]           res;
  logic [SAT_W-1:ACC_WIDTH] unused_res_hi;

  assign acc_x         = {{(SAT_W-ACC_WIDTH){SGN & acc_i[ACC_WIDTH-1]}}, acc_i};
  assign data_x        = {{(SAT_W-DATA_WIDTH){SGN & data_i[DATA_WIDTH-1]}}, data_i};
  assign res           = sat_add(acc_x, data_x, ACC_WIDTH, SGN, SAT);
  assign sum_o         = res[ACC_WIDTH-1:0];
  assign ovf_o         = res[SAT_W];
  assign unused_res_hi = res[SAT_W-1:ACC_WIDTH];

endmodule

// File: rtl/accumulator_multichannel.sv
// NUM_CHANNELS independent accumulators with sticky overflow flags and a
// valid/ready read-and-clear dump port that never stalls accumulation.
module accumulator_multichannel
  import accumulator_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ACC_WIDTH    = 40,
  parameter int NUM_CHANNELS = 4,
  parameter int SIGNED       = 1,
  parameter int SATURATE     = 1,
  localparam int CH_W        = $clog2(NUM_CHANNELS)
) (
  input  logic                    i_CLK,
  input  logic                    i_RESET,
  input  logic                    i_ENABLE,
  input  logic [CH_W-1:0]         i_CHANNEL,
  input  logic [DATA_WIDTH-1:0]   i_DATA_IN,
  input  logic                    i_CLEAR,
  input  logic                    i_DUMP_REQ,
  input  logic [CH_W-1:0]         i_DUMP_CHANNEL,
  input  logic                    i_DUMP_READY,
  output logic                    o_DUMP_VALID,
  output logic [ACC_WIDTH-1:0]    o_DUMP_DATA,
  output logic [CH_W-1:0]         o_DUMP_CHANNEL,
  output logic                    o_DUMP_OVERFLOW,
  output logic                    o_DUMP_BUSY,
  output logic [NUM_CHANNELS-1:0] o_OVERFLOW
);

  if (ACC_WIDTH < DATA_WIDTH) begin : g_bad_acc_width
    $error("ACC_WIDTH must be >= DATA_WIDTH");
  end
  if (ACC_WIDTH >= SAT_W) begin : g_bad_acc_limit
    $error("ACC_WIDTH must be < 64");
  end
  if (NUM_CHANNELS < 2) begin : g_bad_channels
    $error("NUM_CHANNELS must be >= 2");
  end

  logic [ACC_WIDTH-1:0]    acc_q [NUM_CHANNELS];
  logic [ACC_WIDTH-1:0]    acc_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ovf_q;
  logic [NUM_CHANNELS-1:0] ovf_d;
  dump_state_e             state_q;
  logic                    dump_valid_q;
  logic [ACC_WIDTH-1:0]    dump_data_q;
  logic [CH_W-1:0]         dump_channel_q;
  logic                    dump_ovf_q;
  logic                    dump_busy_q;

  logic                    dump_take;
  logic                    base_zero;
  logic [ACC_WIDTH-1:0]    add_base;
  logic [ACC_WIDTH-1:0]    add_sum;
  logic                    add_ovf;

  // A clear or a same-channel dump zeroes the channel before the add lands.
  assign dump_take = (state_q == DUMP_IDLE) && i_DUMP_REQ;
  assign base_zero = i_CLEAR || (dump_take && (i_DUMP_CHANNEL == i_CHANNEL));
  assign add_base  = base_zero ? {ACC_WIDTH{1'b0}} : acc_q[i_CHANNEL];

  accumulator_sat_add #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SIGNED     (SIGNED),
    .SATURATE   (SATURATE)
  ) u_sat_add (
    .acc_i  (add_base),
    .data_i (i_DATA_IN),
    .sum_o  (add_sum),
    .ovf_o  (add_ovf)
  );

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (i_ENABLE && (i_CHANNEL == CH_W'(c))) begin
        acc_d[c] = add_sum;
        ovf_d[c] = (base_zero ? 1'b0 : ovf_q[c]) | add_ovf;
      end else if (i_CLEAR && (i_CHANNEL == CH_W'(c))) begin
        acc_d[c] = {ACC_WIDTH{1'b0}};
        ovf_d[c] = 1'b0;
      end else if (dump_take && (i_DUMP_CHANNEL == CH_W'(c))) begin
        acc_d[c] = {ACC_WIDTH{1'b0}};
        ovf_d[c] = 1'b0;
      end else begin
        acc_d[c] = acc_q[c];
        ovf_d[c] = ovf_q[c];
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      acc_q <= '{default: {ACC_WIDTH{1'b0}}};
      ovf_q <= {NUM_CHANNELS{1'b0}};
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  // Dump handshake; captures the pre-update total of the requested channel.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q        <= DUMP_IDLE;
      dump_valid_q   <= 1'b0;
      dump_data_q    <= {ACC_WIDTH{1'b0}};
      dump_channel_q <= {CH_W{1'b0}};
      dump_ovf_q     <= 1'b0;
      dump_busy_q    <= 1'b0;
    end else begin
      case (state_q)
        DUMP_IDLE: begin
          if (i_DUMP_REQ) begin
            state_q        <= DUMP_HOLD;
            dump_valid_q   <= 1'b1;
            dump_busy_q    <= 1'b1;
            dump_data_q    <= acc_q[i_DUMP_CHANNEL];
            dump_channel_q <= i_DUMP_CHANNEL;
            dump_ovf_q     <= ovf_q[i_DUMP_CHANNEL];
          end else begin
            state_q <= DUMP_IDLE;
          end
        end
        DUMP_HOLD: begin
          if (dump_valid_q && i_DUMP_READY) begin
            state_q      <= DUMP_IDLE;
            dump_valid_q <= 1'b0;
            dump_busy_q  <= 1'b0;
          end else begin
            state_q <= DUMP_HOLD;
          end
        end
        default: begin
          state_q      <= DUMP_IDLE;
          dump_valid_q <= 1'b0;
          dump_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_DUMP_VALID    = dump_valid_q;
  assign o_DUMP_DATA     = dump_data_q;
  assign o_DUMP_CHANNEL  = dump_channel_q;
  assign o_DUMP_OVERFLOW = dump_ovf_q;
  assign o_DUMP_BUSY     = dump_busy_q;
  assign o_OVERFLOW      = ovf_q;

endmodule

// File: tb/tb_accumulator_multichannel.sv
// Directed bench: default build (index 0), 8-bit saturating (1) and 8-bit
// wrapping (2) accumulators sharing clock, reset and data buses.
module tb_accumulator_multichannel;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  en, clr, dreq;
  logic [1:0]  ch, dch;
  logic [31:0] din;
  logic        drdy;

  logic        v0, o0, b0, v1, o1, b1, v2, o2, b2;
  logic [39:0] d0;
  logic [7:0]  d1, d2;
  logic [1:0]  c0, c1, c2;
  logic [3:0]  f0, f1, f2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accumulator_multichannel u_def (
    .i_CLK(clk), .i_RESET(rst), .i_ENABLE(en[0]), .i_CHANNEL(ch), .i_DATA_IN(din),
    .i_CLEAR(clr[0]), .i_DUMP_REQ(dreq[0]), .i_DUMP_CHANNEL(dch), .i_DUMP_READY(drdy),
    .o_DUMP_VALID(v0), .o_DUMP_DATA(d0), .o_DUMP_CHANNEL(c0), .o_DUMP_OVERFLOW(o0),
    .o_DUMP_BUSY(b0), .o_OVERFLOW(f0));

  accumulator_multichannel #(.DATA_WIDTH(8), .ACC_WIDTH(8), .SIGNED(1), .SATURATE(1)) u_sat (
    .i_CLK(clk), .i_RESET(rst), .i_ENABLE(en[1]), .i_CHANNEL(ch), .i_DATA_IN(din[7:0]),
    .i_CLEAR(clr[1]), .i_DUMP_REQ(dreq[1]), .i_DUMP_CHANNEL(dch), .i_DUMP_READY(drdy),
    .o_DUMP_VALID(v1), .o_DUMP_DATA(d1), .o_DUMP_CHANNEL(c1), .o_DUMP_OVERFLOW(o1),
    .o_DUMP_BUSY(b1), .o_OVERFLOW(f1));

  accumulator_multichannel #(.DATA_WIDTH(8), .ACC_WIDTH(8), .SIGNED(1), .SATURATE(0)) u_wrap (
    .i_CLK(clk), .i_RESET(rst), .i_ENABLE(en[2]), .i_CHANNEL(ch), .i_DATA_IN(din[7:0]),
    .i_CLEAR(clr[2]), .i_DUMP_REQ(dreq[2]), .i_DUMP_CHANNEL(dch), .i_DUMP_READY(drdy),
    .o_DUMP_VALID(v2), .o_DUMP_DATA(d2), .o_DUMP_CHANNEL(c2), .o_DUMP_OVERFLOW(o2),
    .o_DUMP_BUSY(b2), .o_OVERFLOW(f2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int k, input logic [1:0] c, input logic [31:0] x);
    en[k] = 1'b1; ch = c; din = x;
    step();
    en[k] = 1'b0;
  endtask

  task automatic dump_req(input int k, input logic [1:0] c);
    dreq[k] = 1'b1; dch = c;
    step();
    dreq[k] = 1'b0;
  endtask

  task automatic accept();
    drdy = 1'b1;
    step();
    drdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_vec++; if ({v0, b0, c0, o0, d0, f0} !== 49'd0) begin n_err++; $display("FAIL reset_def got %h exp 0", {v0, b0, c0, o0, d0, f0}); end
    n_vec++; if ({v1, b1, c1, o1, d1, f1} !== 17'd0) begin n_err++; $display("FAIL reset_sat got %h exp 0", {v1, b1, c1, o1, d1, f1}); end
    n_vec++; if ({v2, b2, c2, o2, d2, f2} !== 17'd0) begin n_err++; $display("FAIL reset_wrap got %h exp 0", {v2, b2, c2, o2, d2, f2}); end
  endtask

  task automatic test_accumulate();
    add(0, 2'd2, 32'd5);
    add(0, 2'd2, 32'd7);
    add(0, 2'd2, 32'hFFFF_FFFE);
    n_vec++; if (f0 !== 4'b0000) begin n_err++; $display("FAIL acc_flags got %b exp 0000", f0); end
    dump_req(0, 2'd2);
    n_vec++; if ({v0, b0, c0, o0, d0} !== {1'b1, 1'b1, 2'd2, 1'b0, 40'd10}) begin
      n_err++; $display("FAIL acc_dump got v%b b%b c%0d o%b d%0d exp v1 b1 c2 o0 d10", v0, b0, c0, o0, d0); end
    accept();
    n_vec++; if ({v0, b0} !== 2'b00) begin n_err++; $display("FAIL acc_release got %b exp 00", {v0, b0}); end
    dump_req(0, 2'd2);
    n_vec++; if ({v0, c0, d0} !== {1'b1, 2'd2, 40'd0}) begin n_err++; $display("FAIL acc_cleared got v%b c%0d d%0d exp v1 c2 d0", v0, c0, d0); end
    accept();
  endtask

  task automatic test_saturate();
    add(1, 2'd0, 32'd100);
    add(1, 2'd0, 32'd100);
    n_vec++; if (f1 !== 4'b0001) begin n_err++; $display("FAIL sat_flag0 got %b exp 0001", f1); end
    add(1, 2'd1, 32'h80);
    add(1, 2'd1, 32'h80);
    n_vec++; if (f1 !== 4'b0011) begin n_err++; $display("FAIL sat_flag1 got %b exp 0011", f1); end
    dump_req(1, 2'd0);
    n_vec++; if ({v1, c1, o1, d1} !== {1'b1, 2'd0, 1'b1, 8'd127}) begin
      n_err++; $display("FAIL sat_pos got v%b c%0d o%b d%h exp v1 c0 o1 d7f", v1, c1, o1, d1); end
    n_vec++; if (f1 !== 4'b0010) begin n_err++; $display("FAIL sat_dump_clr got %b exp 0010", f1); end
    accept();
    dump_req(1, 2'd1);
    n_vec++; if ({v1, c1, o1, d1} !== {1'b1, 2'd1, 1'b1, 8'h80}) begin
      n_err++; $display("FAIL sat_neg got v%b c%0d o%b d%h exp v1 c1 o1 d80", v1, c1, o1, d1); end
    accept();
    n_vec++; if (f1 !== 4'b0000) begin n_err++; $display("FAIL sat_flags_end got %b exp 0000", f1); end
  endtask

  task automatic test_wrap();
    add(2, 2'd0, 32'd100);
    add(2, 2'd0, 32'd100);
    n_vec++; if (f2 !== 4'b0001) begin n_err++; $display("FAIL wrap_flag got %b exp 0001", f2); end
    dump_req(2, 2'd0);
    n_vec++; if ({v2, c2, o2, d2} !== {1'b1, 2'd0, 1'b1, 8'hC8}) begin
      n_err++; $display("FAIL wrap_dump got v%b c%0d o%b d%h exp v1 c0 o1 dc8", v2, c2, o2, d2); end
    accept();
    add(2, 2'd0, 32'd100);
    add(2, 2'd0, 32'd100);
    clr[2] = 1'b1; ch = 2'd0;
    step();
    clr[2] = 1'b0;
    n_vec++; if (f2 !== 4'b0000) begin n_err++; $display("FAIL wrap_clear_flag got %b exp 0000", f2); end
    dump_req(2, 2'd0);
    n_vec++; if ({v2, o2, d2} !== {1'b1, 1'b0, 8'h00}) begin
      n_err++; $display("FAIL wrap_clear_acc got v%b o%b d%h exp v1 o0 d00", v2, o2, d2); end
    accept();
  endtask

  task automatic test_hold();
    add(0, 2'd1, 32'd33);
    add(0, 2'd0, 32'd11);
    dump_req(0, 2'd1);
    n_vec++; if ({v0, b0, c0, d0} !== {1'b1, 1'b1, 2'd1, 40'd33}) begin
      n_err++; $display("FAIL hold_capture got v%b b%b c%0d d%0d exp v1 b1 c1 d33", v0, b0, c0, d0); end
    for (int i = 0; i < 3; i++) begin
      dreq[0] = (i == 0); dch = 2'd0;
      step();
      dreq[0] = 1'b0;
      n_vec++; if ({v0, b0, c0, d0} !== {1'b1, 1'b1, 2'd1, 40'd33}) begin
        n_err++; $display("FAIL hold_stable%0d got v%b b%b c%0d d%0d exp v1 b1 c1 d33", i, v0, b0, c0, d0); end
    end
    drdy = 1'b1; dreq[0] = 1'b1; dch = 2'd0;
    step();
    drdy = 1'b0; dreq[0] = 1'b0;
    n_vec++; if ({v0, b0} !== 2'b00) begin n_err++; $display("FAIL hold_accept got %b exp 00", {v0, b0}); end
    dump_req(0, 2'd0);
    n_vec++; if ({v0, c0, d0} !== {1'b1, 2'd0, 40'd11}) begin
      n_err++; $display("FAIL hold_ignored got v%b c%0d d%0d exp v1 c0 d11", v0, c0, d0); end
    accept();
  endtask

  task automatic test_same_cycle();
    add(0, 2'd3, 32'd20);
    en[0] = 1'b1; ch = 2'd3; din = 32'd9; dreq[0] = 1'b1; dch = 2'd3;
    step();
    en[0] = 1'b0; dreq[0] = 1'b0;
    n_vec++; if ({v0, c0, d0} !== {1'b1, 2'd3, 40'd20}) begin
      n_err++; $display("FAIL same_dump got v%b c%0d d%0d exp v1 c3 d20", v0, c0, d0); end
    accept();
    dump_req(0, 2'd3);
    n_vec++; if ({v0, c0, d0} !== {1'b1, 2'd3, 40'd9}) begin
      n_err++; $display("FAIL same_after got v%b c%0d d%0d exp v1 c3 d9", v0, c0, d0); end
    accept();
    add(0, 2'd2, 32'd4);
    en[0] = 1'b1; clr[0] = 1'b1; ch = 2'd2; din = 32'd6;
    step();
    en[0] = 1'b0; clr[0] = 1'b0;
    dump_req(0, 2'd2);
    n_vec++; if ({v0, c0, d0} !== {1'b1, 2'd2, 40'd6}) begin
      n_err++; $display("FAIL clear_enable got v%b c%0d d%0d exp v1 c2 d6", v0, c0, d0); end
    accept();
  endtask

  task automatic test_reset_hold();
    add(0, 2'd0, 32'd50);
    add(0, 2'd1, 32'd7);
    dump_req(0, 2'd0);
    n_vec++; if ({v0, d0} !== {1'b1, 40'd50}) begin n_err++; $display("FAIL rh_capture got v%b d%0d exp v1 d50", v0, d0); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++; if ({v0, b0, d0, f0} !== 46'd0) begin
      n_err++; $display("FAIL rh_drop got v%b b%b d%0d f%b exp all 0", v0, b0, d0, f0); end
    dump_req(0, 2'd0);
    n_vec++; if ({v0, c0, d0} !== {1'b1, 2'd0, 40'd0}) begin
      n_err++; $display("FAIL rh_ch0 got v%b c%0d d%0d exp v1 c0 d0", v0, c0, d0); end
    accept();
    dump_req(0, 2'd1);
    n_vec++; if ({v0, c0, d0} !== {1'b1, 2'd1, 40'd0}) begin
      n_err++; $display("FAIL rh_ch1 got v%b c%0d d%0d exp v1 c1 d0", v0, c0, d0); end
    accept();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 3'b000; clr = 3'b000; dreq = 3'b000;
    ch = 2'd0; dch = 2'd0; din = 32'd0; drdy = 1'b0;
    test_reset();
    test_accumulate();
    test_saturate();
    test_wrap();
    test_hold();
    test_same_cycle();
    test_reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
